// File: rtl/bcd_step_counter.sv
// bcd_step_counter
//   Multi-digit BCD up/down counter that advances once per rising edge of
//   the level input `step`. It also supports direction select, a synchronous
//   parallel load with per-digit clamping, and either wrap or saturate
//   behaviour at the limits.
//
//   Optional build macro: SEG_SCAN_EN
//     When defined, a digit scanner is added that drives a multiplexed,
//     active-low 7-segment display through the extra outputs `seg` and `an`.
//
// Parameters
//   DIGITS   - number of BCD digits (count width is 4*DIGITS)
//   WRAP     - 1: wrap around at the limits, 0: saturate at the limits
//   SCAN_DIV - clock cycles each digit is shown (SEG_SCAN_EN only), >= 1
//
// Ports
//   clk      in   system clock; all state changes on the rising edge
//   reset    in   asynchronous reset, active-low
//   step     in   level input; one count per 0->1 transition
//   up       in   1 = count up, 0 = count down
//   load     in   synchronous parallel load, active-high (has priority over step)
//   load_val in   BCD value to load; a digit above 9 is clamped to 9
//   count    out  current BCD count; digit 0 is least significant
//   ovf      out  one-cycle pulse when a step starts from a limit
//   at_max   out  every digit is 9
//   at_min   out  every digit is 0
//   seg      out  (SEG_SCAN_EN) active-low segments, seg[0]=a .. seg[6]=g
//   an       out  (SEG_SCAN_EN) active-low one-hot digit enable
module bcd_step_counter #(
    parameter int DIGITS   = 2,
    parameter int WRAP     = 1,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  ovf,
    output logic                  at_max,
    output logic                  at_min
`ifdef SEG_SCAN_EN
    ,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
`endif
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_reg, count_next;
    logic              ovf_reg, ovf_next;
    logic              step_q_reg;
    logic              step_edge;
    logic [W-1:0]      inc_val, dec_val, load_clamped;
    logic [DIGITS-1:0] digit_nine, digit_zero;

    assign step_edge = step & ~step_q_reg;

    // Per-digit increment/decrement. The carry (borrow) into a digit is
    // taken directly from "all lower digits are 9 (0)" instead of a rippled
    // chain, so the whole update still settles within one cycle.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] d;
        logic [3:0] ld;
        logic       carry_in;
        logic       borrow_in;

        assign d  = count_reg[4*gi +: 4];
        assign ld = load_val[4*gi +: 4];

        assign digit_nine[gi] = (d == 4'd9);
        assign digit_zero[gi] = (d == 4'd0);

        if (gi == 0) begin : g_lsd
            assign carry_in  = 1'b1;
            assign borrow_in = 1'b1;
        end else begin : g_upper
            assign carry_in  = &digit_nine[gi-1:0];
            assign borrow_in = &digit_zero[gi-1:0];
        end

        assign inc_val[4*gi +: 4] = !carry_in  ? d : (digit_nine[gi] ? 4'd0 : d + 4'd1);
        assign dec_val[4*gi +: 4] = !borrow_in ? d : (digit_zero[gi] ? 4'd9 : d - 4'd1);
        assign load_clamped[4*gi +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    end

    assign at_max = &digit_nine;
    assign at_min = &digit_zero;

    // All-9s incremented naturally rolls to zero and all-0s decremented
    // naturally rolls to all-9s, so wrap mode needs no special value; only
    // saturate mode has to hold the count.
    always_comb begin
        count_next = count_reg;
        ovf_next   = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (step_edge && up) begin
            ovf_next   = at_max;
            count_next = (at_max && (WRAP == 0)) ? count_reg : inc_val;
        end else if (step_edge) begin
            ovf_next   = at_min;
            count_next = (at_min && (WRAP == 0)) ? count_reg : dec_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            step_q_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            step_q_reg <= step;
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

`ifdef SEG_SCAN_EN
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0] div_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [3:0]       digit_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            div_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign digit_sel = count_reg[{idx_reg, 2'b00} +: 4];
    assign an        = ~(DIGITS'(1) << idx_reg);

    // Active-low segment patterns, bit order g..a
    always_comb begin
        seg = 7'b1111111;
        case (digit_sel)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
`endif

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter
//   Drives a wrapping and a saturating 2-digit counter from shared inputs.
//   An integer-valued behavioural model tracks both, and the outputs are
//   compared against it on every falling clock edge. Directed sequences pin
//   the model with literal values; a randomized phase follows.
module tb_bcd_step_counter;

    localparam int D    = 2;
    localparam int MAXV = 99;
    localparam int SD   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] count_w, count_s;
    logic       ovf_w, ovf_s, at_max_w, at_max_s, at_min_w, at_min_s;
`ifdef SEG_SCAN_EN
    logic [6:0] seg_w, seg_s;
    logic [1:0] an_w, an_s;
`endif

    int tests = 0;
    int fails = 0;
    int ovf_cnt_w = 0;
    int ovf_cnt_s = 0;

    // behavioural model state: counts as plain integers 0..99
    int m_w = 0;
    int m_s = 0;
    bit mo_w = 1'b0;
    bit mo_s = 1'b0;
    bit m_prev = 1'b0;
    int scan_cyc = 0;

    always #5 clk = ~clk;

    bcd_step_counter #(.DIGITS(D), .WRAP(1), .SCAN_DIV(SD)) dut_w (
        .clk(clk), .reset(reset), .step(step), .up(up), .load(load),
        .load_val(load_val), .count(count_w), .ovf(ovf_w),
        .at_max(at_max_w), .at_min(at_min_w)
`ifdef SEG_SCAN_EN
        , .seg(seg_w), .an(an_w)
`endif
    );

    bcd_step_counter #(.DIGITS(D), .WRAP(0), .SCAN_DIV(SD)) dut_s (
        .clk(clk), .reset(reset), .step(step), .up(up), .load(load),
        .load_val(load_val), .count(count_s), .ovf(ovf_s),
        .at_max(at_max_s), .at_min(at_min_s)
`ifdef SEG_SCAN_EN
        , .seg(seg_s), .an(an_s)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [6:0] seg_of(input int dgt);
        case (dgt)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_w = 0; m_s = 0; mo_w = 1'b0; mo_s = 1'b0; m_prev = 1'b0; scan_cyc = 0;
        end else begin
            bit e;
            e = step && !m_prev;
            m_prev = step;
            scan_cyc++;
            mo_w = 1'b0;
            mo_s = 1'b0;
            if (load) begin
                m_w = clamp_val(load_val);
                m_s = m_w;
            end else if (e && up) begin
                if (m_w == MAXV) begin m_w = 0; mo_w = 1'b1; end else m_w++;
                if (m_s == MAXV) mo_s = 1'b1; else m_s++;
            end else if (e) begin
                if (m_w == 0) begin m_w = MAXV; mo_w = 1'b1; end else m_w--;
                if (m_s == 0) mo_s = 1'b1; else m_s--;
            end
        end
    end

    // Compare process: outputs are stable away from the rising edge
    always @(negedge clk) begin
        check("count_wrap", 32'(count_w), 32'(to_bcd(m_w)));
        check("count_sat",  32'(count_s), 32'(to_bcd(m_s)));
        check("ovf_wrap",   32'(ovf_w),   32'(mo_w));
        check("ovf_sat",    32'(ovf_s),   32'(mo_s));
        check("at_max_wrap", 32'(at_max_w), 32'(m_w == MAXV));
        check("at_max_sat",  32'(at_max_s), 32'(m_s == MAXV));
        check("at_min_wrap", 32'(at_min_w), 32'(m_w == 0));
        check("at_min_sat",  32'(at_min_s), 32'(m_s == 0));
        ovf_cnt_w += int'(ovf_w);
        ovf_cnt_s += int'(ovf_s);
`ifdef SEG_SCAN_EN
        begin
            int idx;
            idx = (scan_cyc / SD) % D;
            check("an_wrap",  32'(an_w), (idx == 0) ? 32'h2 : 32'h1);
            check("an_sat",   32'(an_s), (idx == 0) ? 32'h2 : 32'h1);
            check("seg_wrap", 32'(seg_w), 32'(seg_of((idx == 0) ? m_w % 10 : m_w / 10)));
            check("seg_sat",  32'(seg_s), 32'(seg_of((idx == 0) ? m_s % 10 : m_s / 10)));
        end
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic dir);
        up   = dir;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load     = 1'b0;
    endtask

    initial begin
        // reset state
        cyc(2);
        check("rst_count", 32'(count_w), 32'h00);
        check("rst_ovf",   32'(ovf_w),   32'h0);
        check("rst_at_min", 32'(at_min_w), 32'h1);
`ifdef SEG_SCAN_EN
        check("rst_an", 32'(an_w), 32'h2);
`endif
        reset = 1'b1;
        cyc(1);

        // three separate up steps
        ovf_cnt_w = 0; ovf_cnt_s = 0;
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        check("up3_wrap", 32'(count_w), 32'h03);
        check("up3_sat",  32'(count_s), 32'h03);
        check("up3_no_ovf", 32'(ovf_cnt_w + ovf_cnt_s), 32'h0);

        // load 98 then two up steps through the top
        do_load(8'h98);
        check("load98", 32'(count_w), 32'h98);
        ovf_cnt_w = 0; ovf_cnt_s = 0;
        pulse(1'b1);
        check("to99", 32'(count_w), 32'h99);
        check("at_max99", 32'(at_max_w), 32'h1);
        pulse(1'b1);
        check("wrap_to00", 32'(count_w), 32'h00);
        check("sat_hold99", 32'(count_s), 32'h99);
        check("ovf_once_wrap", 32'(ovf_cnt_w), 32'h1);
        check("ovf_once_sat",  32'(ovf_cnt_s), 32'h1);

        // down step from zero
        do_load(8'h00);
        ovf_cnt_w = 0; ovf_cnt_s = 0;
        pulse(1'b0);
        check("wrap_to99", 32'(count_w), 32'h99);
        check("sat_hold00", 32'(count_s), 32'h00);
        check("ovf_down_sat", 32'(ovf_cnt_s), 32'h1);
        pulse(1'b1);
        check("sat_up01", 32'(count_s), 32'h01);

        // step held high counts once, toggles count each time
        do_load(8'h00);
        up = 1'b1;
        step = 1'b1;
        cyc(10);
        step = 1'b0;
        cyc(1);
        check("held_once", 32'(count_w), 32'h01);
        repeat (5) pulse(1'b1);
        check("toggle5", 32'(count_w), 32'h06);

        // borrow across digits
        do_load(8'h10);
        pulse(1'b0);
        check("borrow_09", 32'(count_w), 32'h09);

        // load with a clamped digit wins over a simultaneous step edge
        ovf_cnt_w = 0; ovf_cnt_s = 0;
        step = 1'b1; load = 1'b1; load_val = 8'hA5;
        cyc(1);
        load = 1'b0; step = 1'b0;
        cyc(1);
        check("load_a5_clamp", 32'(count_w), 32'h95);
        check("load_a5_no_ovf", 32'(ovf_cnt_w + ovf_cnt_s), 32'h0);

        // asynchronous reset between edges
        do_load(8'h42);
        check("load42", 32'(count_w), 32'h42);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", 32'(count_w), 32'h00);
        check("async_rst_ovf",   32'(ovf_w),   32'h0);
        cyc(1);
        reset = 1'b1;
        cyc(1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            step     = 1'($urandom_range(0, 1));
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom);
            reset    = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        reset = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
